lfsr_checker: RTL

- Receive-side companion to the 8-bit LFSR generator: takes the generator's sample stream, self-synchronises a local LFSR to it, then flags and counts every sample that departs from the expected sequence.
- Sits at the far end of a link or loopback path under test.
- Result is reported as a lock flag, a per-error pulse and a saturating error counter.

---
 rtl/lfsr_checker.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/lfsr_checker.sv
// Receive-side LFSR checker: self-synchronises a local Fibonacci LFSR to an
// incoming sample stream, then flags and counts samples that leave the sequence.
module lfsr_checker #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] TAPS       = 8'hB8,
  parameter int               LOCK_COUNT = 4,
  parameter int               LOSS_COUNT = 3,
  parameter int               CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] lfsr,
  input  logic             clr_count,
  output logic             locked,
  output logic             error,
  output logic [CNT_W-1:0] err_count,
  output logic [WIDTH-1:0] expected
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int LW = $clog2(LOSS_COUNT + 1);

  localparam logic [MW-1:0]    LOCK_V  = MW'(LOCK_COUNT);
  localparam logic [LW-1:0]    LOSS_V  = LW'(LOSS_COUNT);
  localparam logic [MW-1:0]    M_ONE   = MW'(1'b1);
  localparam logic [LW-1:0]    L_ONE   = LW'(1'b1);
  localparam logic [MW-1:0]    M_ZERO  = {MW{1'b0}};
  localparam logic [LW-1:0]    L_ZERO  = {LW{1'b0}};
  localparam logic [CNT_W-1:0] C_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] C_MAX   = {CNT_W{1'b1}};
  localparam logic [WIDTH-1:0] W_ZERO  = {WIDTH{1'b0}};

  typedef enum logic [0:0] {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Fibonacci step: shift left, feedback is the parity of the tapped bits.
  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  logic [1:0]       rst_sync_r;
  logic             rst_n_s;

  state_t           state_r,  state_s;
  logic             seeded_r, seeded_s;
  logic [MW-1:0]    match_r,  match_s;
  logic [LW-1:0]    miss_r,   miss_s;
  logic [WIDTH-1:0] exp_r,    exp_s;
  logic [CNT_W-1:0] cnt_r,    cnt_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             error_r,  error_s;
  logic             locked_r, locked_s;
  logic             hit_s;

  // Reset asserts asynchronously and is released two clock edges later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_r[1];

  // Next-state, prediction and counter logic for SEARCH/LOCKED.
  always_comb begin
    state_s   = state_r;
    seeded_s  = seeded_r;
    match_s   = match_r;
    miss_s    = miss_r;
    exp_s     = exp_r;
    cnt_inc_s = cnt_r;
    error_s   = 1'b0;
    hit_s     = (lfsr == exp_r);

    if (enable) begin
      case (state_r)
        ST_SEARCH: begin
          if (seeded_r && hit_s) begin
            match_s = match_r + M_ONE;
            exp_s   = lfsr_next(exp_r);
            if ((match_r + M_ONE) == LOCK_V) begin
              state_s = ST_LOCKED;
              miss_s  = L_ZERO;
            end else begin
              state_s = ST_SEARCH;
            end
          end else if (lfsr != W_ZERO) begin
            // Any non-zero sample is a valid seed; zero would lock up the LFSR.
            seeded_s = 1'b1;
            exp_s    = lfsr_next(lfsr);
            match_s  = M_ONE;
          end else begin
            seeded_s = 1'b0;
            match_s  = M_ZERO;
          end
        end
        ST_LOCKED: begin
          // Flywheel: the prediction never reloads from the input while locked.
          exp_s = lfsr_next(exp_r);
          if (hit_s) begin
            miss_s = L_ZERO;
          end else begin
            error_s = 1'b1;
            if (cnt_r != C_MAX) begin
              cnt_inc_s = cnt_r + C_ONE;
            end else begin
              cnt_inc_s = cnt_r;
            end
            if ((miss_r + L_ONE) == LOSS_V) begin
              state_s  = ST_SEARCH;
              seeded_s = 1'b0;
              match_s  = M_ZERO;
              miss_s   = L_ZERO;
            end else begin
              miss_s = miss_r + L_ONE;
            end
          end
        end
        default: begin
          state_s  = ST_SEARCH;
          seeded_s = 1'b0;
          match_s  = M_ZERO;
          miss_s   = L_ZERO;
        end
      endcase
    end else begin
      error_s = 1'b0;
    end

    if (clr_count) begin
      cnt_s = C_ZERO;
    end else begin
      cnt_s = cnt_inc_s;
    end

    locked_s = (state_s == ST_LOCKED);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r  <= ST_SEARCH;
      seeded_r <= 1'b0;
      match_r  <= M_ZERO;
      miss_r   <= L_ZERO;
      exp_r    <= W_ZERO;
      cnt_r    <= C_ZERO;
      error_r  <= 1'b0;
      locked_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      seeded_r <= seeded_s;
      match_r  <= match_s;
      miss_r   <= miss_s;
      exp_r    <= exp_s;
      cnt_r    <= cnt_s;
      error_r  <= error_s;
      locked_r <= locked_s;
    end
  end

  assign locked    = locked_r;
  assign error     = error_r;
  assign err_count = cnt_r;
  assign expected  = exp_r;

endmodule
